// File: rtl/fractal_sync_pkg.sv
// Shared definitions for the fractal synchronization node: response port
// count, back-routing dispatcher FSM states and the queued entry width.
package fractal_sync_pkg;

  // One response port per bit of the source/destination mask.
  localparam int unsigned SD_WIDTH = 4;

  // Dispatcher head state: empty, or broadcasting the head entry.
  typedef enum logic {
    BR_IDLE  = 1'b0,
    BR_BCAST = 1'b1
  } br_state_e;

  // Packed width of a queued back-routing entry {sd, idx}.
  function automatic int unsigned br_entry_width(input int unsigned idx_width);
    return SD_WIDTH + idx_width;
  endfunction

endpackage

// File: rtl/fractal_sync_br_fifo.sv
// Multi-write, single-read circular FIFO for back-routing entries. Writes
// from all ports land in one cycle in ascending port order; ready_n_o says
// there is room for a full set of N_IN writes.
module fractal_sync_br_fifo #(
  parameter int unsigned N_IN  = 2,
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [N_IN-1:0]         wr_en_i,
  input  logic [N_IN-1:0][W-1:0]  wr_data_i,
  input  logic                    pop_i,
  output logic                    ready_n_o,
  output logic                    empty_o,
  output logic [W-1:0]            head_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] n_enq;
  logic [PW-1:0] wr_slot [N_IN];

  function automatic logic [PW-1:0] wrap(input int unsigned v);
    return PW'(v % DEPTH);
  endfunction

  // Pack the enabled writes behind the current tail, lowest port first.
  always_comb begin
    n_enq = '0;
    for (int j = 0; j < N_IN; j++) begin
      wr_slot[j] = wrap(32'(rd_ptr_q) + 32'(count_q) + 32'(n_enq));
      if (wr_en_i[j]) n_enq = n_enq + CW'(1);
    end
  end

  // Storage array; contents need no reset since count_q gates visibility.
  always_ff @(posedge clk_i) begin
    for (int j = 0; j < N_IN; j++) begin
      if (wr_en_i[j]) mem_q[wr_slot[j]] <= wr_data_i[j];
    end
  end

  // Read pointer and occupancy; enqueue and pop may coincide.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (pop_i) rd_ptr_q <= wrap(32'(rd_ptr_q) + 32'd1);
      count_q <= count_q + n_enq - CW'(pop_i);
    end
  end

  assign ready_n_o = (count_q <= CW'(DEPTH - N_IN));
  assign empty_o   = (count_q == '0);
  assign head_o    = mem_q[rd_ptr_q];

endmodule

// File: rtl/fractal_sync_br_dispatch.sv
// Back-routing dispatcher: queues barrier-completion events and multicasts
// each one as a wake-up response to every port in its mask, with an
// independent handshake per port and zero-bubble reload of the next entry.
module fractal_sync_br_dispatch
  import fractal_sync_pkg::*;
#(
  parameter int unsigned N_IN       = 2,
  parameter int unsigned IDX_WIDTH  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [N_IN-1:0]                      evt_valid_i,
  input  logic [N_IN-1:0][SD_WIDTH-1:0]        evt_sd_i,
  input  logic [N_IN-1:0][IDX_WIDTH-1:0]       evt_idx_i,
  output logic                                 evt_ready_o,
  output logic [SD_WIDTH-1:0]                  rsp_valid_o,
  output logic [SD_WIDTH-1:0][IDX_WIDTH-1:0]   rsp_idx_o,
  input  logic [SD_WIDTH-1:0]                  rsp_ready_i,
  output logic                                 busy_o
);

  localparam int unsigned EW = br_entry_width(IDX_WIDTH);

  if (FIFO_DEPTH < N_IN) begin : g_depth_check
    $fatal(1, "fractal_sync_br_dispatch: FIFO_DEPTH must be >= N_IN");
  end

  logic [N_IN-1:0]         wr_en;
  logic [N_IN-1:0][EW-1:0] wr_data;
  logic                    fifo_pop;
  logic                    fifo_empty;
  logic [EW-1:0]           fifo_head;
  logic [SD_WIDTH-1:0]     head_sd;
  logic [IDX_WIDTH-1:0]    head_idx;

  br_state_e               state_q, state_next;
  logic [SD_WIDTH-1:0]     mask_q, mask_next, remaining;
  logic [IDX_WIDTH-1:0]    idx_q, idx_next;

  // Zero-mask events are acknowledged but never stored.
  for (genvar gi = 0; gi < N_IN; gi++) begin : g_in
    assign wr_en[gi]   = evt_valid_i[gi] & evt_ready_o & (|evt_sd_i[gi]);
    assign wr_data[gi] = {evt_sd_i[gi], evt_idx_i[gi]};
  end

  fractal_sync_br_fifo #(
    .N_IN  (N_IN),
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) i_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .wr_en_i   (wr_en),
    .wr_data_i (wr_data),
    .pop_i     (fifo_pop),
    .ready_n_o (evt_ready_o),
    .empty_o   (fifo_empty),
    .head_o    (fifo_head)
  );

  assign head_sd   = fifo_head[EW-1:IDX_WIDTH];
  assign head_idx  = fifo_head[IDX_WIDTH-1:0];
  assign remaining = mask_q & ~rsp_ready_i;

  // Head/FSM next state: clear served ports, reload as soon as all are served.
  always_comb begin
    state_next = state_q;
    mask_next  = mask_q;
    idx_next   = idx_q;
    fifo_pop   = 1'b0;
    unique case (state_q)
      BR_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          mask_next  = head_sd;
          idx_next   = head_idx;
          state_next = BR_BCAST;
        end
      end
      BR_BCAST: begin
        mask_next = remaining;
        if (remaining == '0) begin
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            mask_next = head_sd;
            idx_next  = head_idx;
          end else begin
            idx_next   = '0;
            state_next = BR_IDLE;
          end
        end
      end
      default: state_next = BR_IDLE;
    endcase
  end

  // Head register and FSM state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= BR_IDLE;
      mask_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_next;
      mask_q  <= mask_next;
      idx_q   <= idx_next;
    end
  end

  // Each still-pending port sees the head index; others are held at zero.
  for (genvar gi = 0; gi < SD_WIDTH; gi++) begin : g_out
    assign rsp_valid_o[gi] = mask_q[gi];
    assign rsp_idx_o[gi]   = mask_q[gi] ? idx_q : '0;
  end

  assign busy_o = (state_q == BR_BCAST) | ~fifo_empty;

endmodule
